// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe
// Two-stage pipelined floating-point comparator with a valid/ready handshake.
// Each operand pair yields exactly one of gt/eq/lt/unord, two cycles after it is
// accepted. Zero and NaN semantics: +0 == -0, and any NaN gives unord.
// abs_mode compares |a| against |b|. A tag travels with each pair.
//
// S1 classifies each operand: sign, NaN, zero, magnitude.
// S2 applies the ordering rules and registers the flags and the tag.
// A stall freezes both stages together.
//
// Optional feature macro: FPCMP_DENORM_FLUSH_EN.
//   Defined:   any operand with a zero exponent is treated as zero.
//   Undefined: subnormals order exactly by magnitude.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = !out_valid || out_ready)
//   a, b                operands {sign, exponent[EXP_W], mantissa[MAN_W]}
//   abs_mode            1 = ignore sign bits
//   in_tag              sideband tag captured with the pair
//   out_valid/out_ready output handshake
//   a_gt_b, a_eq_b,
//   a_lt_b, unord       mutually exclusive result flags
//   out_tag             tag of the pair producing this result
module fp_compare_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             abs_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             unord,
  output logic [TAG_W-1:0] out_tag
);

  localparam int MAG_W = EXP_W + MAN_W;

  // Result vector encoding: {gt, eq, lt, unord}
  localparam logic [3:0] RES_GT = 4'b1000;
  localparam logic [3:0] RES_EQ = 4'b0100;
  localparam logic [3:0] RES_LT = 4'b0010;
  localparam logic [3:0] RES_UN = 4'b0001;

  function automatic logic is_nan(input logic [W-1:0] op);
    return (&op[MAG_W-1:MAN_W]) && (|op[MAN_W-1:0]);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] op);
`ifdef FPCMP_DENORM_FLUSH_EN
    return ~|op[MAG_W-1:MAN_W];
`else
    return ~|op[MAG_W-1:0];
`endif
  endfunction

  // Infinities need no special case: their all-ones exponent with a zero
  // mantissa already sorts above every finite magnitude.
  function automatic logic [3:0] compare(
    input logic             sa,
    input logic             sb,
    input logic             na,
    input logic             nb,
    input logic             za,
    input logic             zb,
    input logic [MAG_W-1:0] ma,
    input logic [MAG_W-1:0] mb
  );
    logic [3:0] r;
    if (na || nb)        r = RES_UN;
    else if (za && zb)   r = RES_EQ;
    else if (sa != sb)   r = sa ? RES_LT : RES_GT;
    else if (ma == mb)   r = RES_EQ;
    else if (!sa)        r = (ma > mb) ? RES_GT : RES_LT;
    else                 r = (ma > mb) ? RES_LT : RES_GT;
    return r;
  endfunction

  logic adv;

  logic             vld_p1_q;
  logic             sa_p1_q, sb_p1_q;
  logic             na_p1_q, nb_p1_q;
  logic             za_p1_q, zb_p1_q;
  logic [MAG_W-1:0] ma_p1_q, mb_p1_q;
  logic             abs_p1_q;
  logic [TAG_W-1:0] tag_p1_q;

  logic             sa_d, sb_d;

  logic             vld_p2_q;
  logic [3:0]       res_p2_q;
  logic [TAG_W-1:0] tag_p2_q;
  logic [3:0]       res_d;
  logic [TAG_W-1:0] tag_d;

  assign adv      = !vld_p2_q || out_ready;
  assign in_ready = adv;

  // ---- S1: classify ----
  always_comb begin
    sa_d = a[W-1] & ~abs_mode;
    sb_d = b[W-1] & ~abs_mode;
  end

  always_ff @(posedge clk) begin
    if (rst)      vld_p1_q <= 1'b0;
    else if (adv) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sa_p1_q  <= sa_d;
      sb_p1_q  <= sb_d;
      na_p1_q  <= is_nan(a);
      nb_p1_q  <= is_nan(b);
      za_p1_q  <= is_zero(a);
      zb_p1_q  <= is_zero(b);
      ma_p1_q  <= a[MAG_W-1:0];
      mb_p1_q  <= b[MAG_W-1:0];
      abs_p1_q <= abs_mode;
      tag_p1_q <= in_tag;
    end
  end

  // ---- S2: compare and register outputs ----
  // Flags and tag are zeroed for bubbles so idle outputs read as all zero.
  always_comb begin
    res_d = 4'b0000;
    tag_d = '0;
    if (vld_p1_q) begin
      res_d = compare(sa_p1_q & ~abs_p1_q, sb_p1_q & ~abs_p1_q,
                      na_p1_q, nb_p1_q, za_p1_q, zb_p1_q, ma_p1_q, mb_p1_q);
      tag_d = tag_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= 4'b0000;
      tag_p2_q <= '0;
    end else if (adv) begin
      vld_p2_q <= vld_p1_q;
      res_p2_q <= res_d;
      tag_p2_q <= tag_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign a_gt_b    = res_p2_q[3];
  assign a_eq_b    = res_p2_q[2];
  assign a_lt_b    = res_p2_q[1];
  assign unord     = res_p2_q[0];
  assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
module tb_fp_compare_pipe;

  localparam logic [3:0] GT = 4'b1000;
  localparam logic [3:0] EQ = 4'b0100;
  localparam logic [3:0] LT = 4'b0010;
  localparam logic [3:0] UN = 4'b0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        abs_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [15:0] ha = '0;
  logic [15:0] hb = '0;
  logic [3:0]  in_tag = '0;

  logic        in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, unord;
  logic [3:0]  out_tag;
  logic        h_in_ready, h_out_valid, h_gt, h_eq, h_lt, h_un;
  logic [3:0]  h_out_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .abs_mode(abs_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .unord(unord),
    .out_tag(out_tag)
  );

  fp_compare_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(h_in_ready),
    .a(ha), .b(hb), .abs_mode(abs_mode), .in_tag(in_tag),
    .out_valid(h_out_valid), .out_ready(out_ready),
    .a_gt_b(h_gt), .a_eq_b(h_eq), .a_lt_b(h_lt), .unord(h_un),
    .out_tag(h_out_tag)
  );

  wire [3:0] flags  = {a_gt_b, a_eq_b, a_lt_b, unord};
  wire [3:0] hflags = {h_gt, h_eq, h_lt, h_un};

  // Reference: place each non-NaN operand on a signed number line
  // (zero -> 0, otherwise +/- its magnitude field) and compare the keys.
  function automatic longint num_key(input logic [31:0] x, input logic am);
    longint mag;
    bit     zero;
    mag = longint'(x[30:0]);
`ifdef FPCMP_DENORM_FLUSH_EN
    zero = (x[30:23] == 8'h00);
`else
    zero = (x[30:0] == 31'h0);
`endif
    if (zero) return 0;
    return (x[31] && !am) ? -mag : mag;
  endfunction

  function automatic logic [3:0] model(input logic [31:0] x, input logic [31:0] y,
                                       input logic am);
    longint kx, ky;
    if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0))
      return UN;
    kx = num_key(x, am);
    ky = num_key(y, am);
    if (kx > ky) return GT;
    if (kx < ky) return LT;
    return EQ;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      3: return {s, 8'h00, 23'($urandom_range(0, 32'h7FFFFF))};
      4: return {s, 8'($urandom_range(126, 128)), 23'($urandom_range(0, 3))};
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, settle, outputs then readable.
  task automatic cyc(input logic v, input logic [31:0] x, input logic [31:0] y,
                     input logic m, input logic [3:0] t, input logic r, input logic rs);
    @(negedge clk);
    rst = rs; in_valid = v; a = x; b = y; ha = x[15:0]; hb = y[15:0];
    abs_mode = m; in_tag = t; out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || flags !== 4'b0 || out_tag !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b flags=%b tag=%0d ready=%b, expected 0 0000 0 1",
               out_valid, flags, out_tag, in_ready);
    end
    checks++;
    if (h_out_valid !== 1'b0 || hflags !== 4'b0 || h_out_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_state_half: valid=%b flags=%b tag=%0d, expected 0 0000 0",
               h_out_valid, hflags, h_out_tag);
    end
  endtask

  task automatic test_basic;
    logic [31:0] xa [3] = '{32'h3F800000, 32'hC0000000, 32'h00000000};
    logic [31:0] xb [3] = '{32'h40000000, 32'hBF800000, 32'h80000000};
    logic [3:0]  ex [3] = '{LT, LT, EQ};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) cyc(1, xa[i], xb[i], 0, 4'(i + 1), 1, 0);
      else       cyc(0, 0, 0, 0, 0, 1, 0);
      if (i == 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_latency: out_valid=%b one cycle after accept, expected 0", out_valid);
        end
      end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || flags !== ex[i-2] || out_tag !== 4'(i - 1)) begin
          errors++;
          $display("FAIL basic_res%0d: valid=%b flags=%b tag=%0d, expected 1 %b %0d",
                   i - 2, out_valid, flags, out_tag, ex[i-2], i - 1);
        end
      end
    end
  endtask

  task automatic test_special;
    // NaN, infinity/sign, abs_mode and subnormal pairs streamed back to back.
    logic [31:0] xa [10] = '{32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'hC1280000,
                             32'hFF800000, 32'hC1A40000, 32'hC1A40000, 32'hBDCCCCCD,
                             32'h00000002, 32'h00000001};
    logic [31:0] xb [10] = '{32'h3F800000, 32'h7F800001, 32'h461C4000, 32'hC1A40000,
                             32'hFF800000, 32'h41280000, 32'h41280000, 32'h3DCCCCCD,
                             32'h00000001, 32'h80000000};
    logic        am [10] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
`ifdef FPCMP_DENORM_FLUSH_EN
    logic [3:0]  ex [10] = '{UN, UN, GT, GT, EQ, GT, LT, EQ, EQ, EQ};
`else
    logic [3:0]  ex [10] = '{UN, UN, GT, GT, EQ, GT, LT, EQ, GT, GT};
`endif
    for (int i = 0; i < 12; i++) begin
      if (i < 10) cyc(1, xa[i], xb[i], am[i], 4'(i + 4), 1, 0);
      else        cyc(0, 0, 0, 0, 0, 1, 0);
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || flags !== ex[i-2] || out_tag !== 4'(i + 2)) begin
          errors++;
          $display("FAIL special_%0d: valid=%b flags=%b tag=%0d, expected 1 %b %0d",
                   i - 2, out_valid, flags, out_tag, ex[i-2], i + 2);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    cyc(1, 32'h40000000, 32'h3F800000, 0, 4'd5, 1, 0);   // gt
    cyc(1, 32'hBF800000, 32'h3F800000, 0, 4'd6, 1, 0);   // lt
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h3F800000, 32'h3F800000, 0, 4'd7, 0, 0); // eq, held off
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || flags !== GT || out_tag !== 4'd5) begin
        errors++;
        $display("FAIL stall_hold%0d: ready=%b valid=%b flags=%b tag=%0d, expected 0 1 %b 5",
                 i, in_ready, out_valid, flags, out_tag, GT);
      end
    end
    cyc(1, 32'h3F800000, 32'h3F800000, 0, 4'd7, 1, 0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || flags !== GT || out_tag !== 4'd5) begin
      errors++;
      $display("FAIL stall_release: ready=%b valid=%b flags=%b tag=%0d, expected 1 1 %b 5",
               in_ready, out_valid, flags, out_tag, GT);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || flags !== LT || out_tag !== 4'd6) begin
      errors++;
      $display("FAIL drain_2: valid=%b flags=%b tag=%0d, expected 1 %b 6", out_valid, flags, out_tag, LT);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || flags !== EQ || out_tag !== 4'd7) begin
      errors++;
      $display("FAIL drain_3: valid=%b flags=%b tag=%0d, expected 1 %b 7", out_valid, flags, out_tag, EQ);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    cyc(1, 32'h40000000, 32'h3F800000, 0, 4'd9, 1, 0);
    cyc(1, 32'hBF800000, 32'h3F800000, 0, 4'd10, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (out_valid !== 1'b0 || flags !== 4'b0 || out_tag !== 4'd0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset_%0d: valid=%b flags=%b tag=%0d ready=%b, expected 0 0000 0 1",
                 i, out_valid, flags, out_tag, in_ready);
      end
    end
  endtask

  task automatic test_half_precision;
    logic [15:0] xa [3] = '{16'h3C00, 16'hC000, 16'h0000};
    logic [15:0] xb [3] = '{16'h4000, 16'hBC00, 16'h8000};
    logic [3:0]  ex [3] = '{LT, LT, EQ};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) cyc(1, {16'h0, xa[i]}, {16'h0, xb[i]}, 0, 4'(i + 1), 1, 0);
      else       cyc(0, 0, 0, 0, 0, 1, 0);
      if (i >= 2) begin
        checks++;
        if (h_out_valid !== 1'b1 || hflags !== ex[i-2] || h_out_tag !== 4'(i - 1)) begin
          errors++;
          $display("FAIL half_res%0d: valid=%b flags=%b tag=%0d, expected 1 %b %0d",
                   i - 2, h_out_valid, hflags, h_out_tag, ex[i-2], i - 1);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0]  sb_q [$];
    logic [7:0]  exp_e;
    logic [31:0] x, y;
    for (int n = 0; n < 620; n++) begin
      x = rnd_op();
      y = ($urandom_range(0, 4) == 0) ? (x ^ {1'($urandom_range(0, 1)), 31'h0}) : rnd_op();
      if (n < 600)
        cyc(1'($urandom_range(0, 3) != 0), x, y, 1'($urandom_range(0, 3) == 0),
            4'($urandom), 1'($urandom_range(0, 3) != 0), 0);
      else
        cyc(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL rand_ready n=%0d: in_ready=%b valid=%b out_ready=%b",
                 n, in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious n=%0d: flags=%b tag=%0d with nothing outstanding",
                   n, flags, out_tag);
        end else begin
          exp_e = sb_q.pop_front();
          if ({flags, out_tag} !== exp_e) begin
            errors++;
            $display("FAIL rand_result n=%0d: flags=%b tag=%0d, expected %b %0d",
                     n, flags, out_tag, exp_e[7:4], exp_e[3:0]);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back({model(a, b, abs_mode), in_tag});
    end
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: %0d results still outstanding, out_valid=%b, expected 0 0",
               sb_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_backpressure();
    test_reset_midflight();
    test_half_precision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point comparator.
- Takes operand pairs under a valid/ready handshake and returns mutually exclusive gt/eq/lt/unordered flags two cycles later.
- Fixes zero and NaN semantics: +0 == -0, and any NaN gives unordered.
- Adds a per-transaction magnitude-compare mode and a tag that travels with each result.
- Used by the CORDIC angle-range and quadrant logic wherever a registered, back-pressurable comparison is needed.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa (fraction) field width.
- TAG_W, 4, width of the opaque sideband tag carried alongside each operand pair.
- Derived, not overridable: W = 1+EXP_W+MAN_W, the operand width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand pair present.
- in_ready, output, 1, block accepts the pair this cycle.
- a, input, W, operand A as {sign, exponent, mantissa}.
- b, input, W, operand B.
- abs_mode, input, 1, 1 = compare |a| against |b|, ignoring sign bits.
- in_tag, input, TAG_W, sideband tag.
- out_valid, output, 1, result present.
- out_ready, input, 1, downstream accepts the result.
- a_gt_b, output, 1, a > b.
- a_eq_b, output, 1, a == b.
- a_lt_b, output, 1, a < b.
- unord, output, 1, at least one operand is NaN.
- out_tag, output, TAG_W, tag of the transaction producing this result.

Behaviour:
- One clock domain: clk. Reset: rst is synchronous and active-high. All state clears on the clk edge where rst=1.
- Reset values: out_valid=0; a_gt_b, a_eq_b, a_lt_b and unord all 0; out_tag=0; stage-1 valid=0.
- Reset mid-operation discards in-flight transactions. in_ready is 1 in the cycle after reset.
- Pipeline structure: two register stages, S1 (classify) and S2 (compare/output).
- Advance condition: adv = !out_valid || out_ready. in_ready = adv, computed combinationally.
- Acceptance: a transfer occurs when in_valid && in_ready.
- When adv=1: S1 loads the input (valid = in_valid), and S2 loads S1.
- When adv=0: both stages hold all contents.
- Latency: result appears exactly 2 cycles after acceptance with no stall. Full throughput is 1 result per cycle.
- Output stability: while out_valid && !out_ready, all outputs stay constant.
- A stall freezes S1 as well; no bubble collapsing.
- S1 classification, per operand:
  - Field split: s = MSB; e = next EXP_W bits; m = low MAN_W bits.
  - nan = (e all ones) && (m != 0).
  - zero = (e == 0) && (m == 0).
  - mag = {e, m}.
  - In abs_mode, s is forced to 0 before S1 registers.
  - S1 registers s, nan, zero, mag, abs_mode and tag.
- S2 result rules, applied in priority order:
  - If either operand is NaN: unord=1; gt, eq, lt = 0.
  - Else if both operands are zero (any signs): eq=1.
  - Else if sa != sb: the positive operand is greater.
  - Else if sa = sb = 0: compare mag unsigned (larger mag is greater; equal mag gives eq).
  - Else (sa = sb = 1): compare mag unsigned, inverted (larger mag is less; equal mag gives eq).
- Infinities need no special case: mag = all-ones exponent with zero mantissa orders correctly, so +Inf == +Inf and -Inf < any finite value.
- Exactly one of gt/eq/lt/unord is 1 whenever out_valid=1.
- Flag and tag outputs are registered in S2.
- out_tag equals the in_tag captured with the same pair.

Optional Feature:
- Macro: FPCMP_DENORM_FLUSH_EN.
- Defined: any operand with e == 0 is classified as zero in S1, regardless of mantissa.
  - Example: 32'h00000001 == 32'h80000000 gives eq=1.
  - Example: 32'h00000001 vs 32'h00000002 gives eq=1.
- Undefined: subnormals compare exactly by mag; only m == 0 with e == 0 counts as zero.
  - Example: 32'h00000002 > 32'h00000001 gives gt=1.
- No port or latency change either way.

Test Plan:
1. Default params, out_ready=1, back-to-back pairs (3F800000, 40000000), (C0000000, BF800000), (00000000, 80000000), with tags 1, 2, 3 -> on consecutive cycles starting 2 cycles after the first acceptance: lt/tag1, lt/tag2, eq/tag3.
2. NaN: a=7FC00000, b=3F800000; then a=7F800000, b=7F800001 -> unord=1 and gt/eq/lt=0 for both.
3. Sign and infinity: a=7F800000, b=461C4000 -> gt. a=C1280000, b=C1A40000 -> gt. a=FF800000, b=FF800000 -> eq.
4. abs_mode=1: a=C1A40000, b=41280000 -> gt. Same pair with abs_mode=0 -> lt. a=BDCCCCCD, b=3DCCCCCD with abs_mode=1 -> eq.
5. Backpressure: issue 3 pairs; hold out_ready=0 for 4 cycles once out_valid rises -> in_ready=0 during the stall; first result and tag held stable throughout; all 3 results drain in order with none lost or duplicated once out_ready=1.
6. Reset mid-flight: accept 2 pairs, assert rst for 1 cycle -> next cycle out_valid=0, all flags 0, out_tag=0, in_ready=1, and neither old result ever appears. Repeat test 1 with EXP_W=5, MAN_W=10 using 3C00 vs 4000 -> lt.
